tick_period_meter: RTL and testbench
====================================

# tick_period_meter

Receive-side companion to the clock divider: consumes the divider's carry-out strobe and recovers its period in clock-enable units. Counts CE-qualified cycles between successive ticks, publishes each measured period with a one-cycle valid strobe, and reports lock once the period is stable. Used to verify and monitor divided clock enables and to let downstream logic adapt to the active divide ratio.

## Interface

Parameters:
- WIDTH, 8: width of the period counter and the PERIOD output; maximum measurable period is 2^WIDTH-1.
- LOCK_COUNT, 2: number of consecutive identical measurements required to assert LOCK; legal range 1 to 15.

Ports:
- CLK  input  1  system clock; all state is updated on the rising edge.
- NRST  input  1  asynchronous, active-low reset.
- CE  input  1  clock enable; counting and TICK sampling happen only on cycles where CE=1.
- CLR  input  1  synchronous clear; overrides every other input except NRST.
- TICK  input  1  period strobe, normally the divider's CO; sampled only when CE=1.
- PERIOD  output  WIDTH  last measured period, held until the next measurement.
- VALID  output  1  one-cycle pulse; PERIOD was updated at the same edge.
- LOCK  output  1  LOCK_COUNT consecutive identical periods have been seen.
- OVF  output  1  sticky overflow flag; no tick arrived within 2^WIDTH-1 enabled cycles.

## Operation

- States: IDLE (waiting for the first tick) and MEASURE (counting enabled cycles since the last tick).
- IDLE:
  - An enabled cycle with TICK=1 loads cnt=1 and moves to MEASURE.
  - No output changes on this first tick.
- MEASURE, enabled cycle, TICK=1:
  - PERIOD<=cnt, VALID<=1, cnt<=1, stay in MEASURE, OVF<=0.
- MEASURE, enabled cycle, TICK=0, cnt<max:
  - cnt<=cnt+1.
- MEASURE, enabled cycle, TICK=0, cnt==max (2^WIDTH-1):
  - OVF<=1, LOCK<=0, match count cleared, go to IDLE.
  - PERIOD holds its value; VALID stays 0.
- A TICK arriving exactly when cnt==max is a valid measurement with PERIOD=max. It is not an overflow.
- Period definition: the number of enabled cycles from one tick (exclusive) to the next tick (inclusive).
  - Ticks on back-to-back enabled cycles give PERIOD=1.
  - A tick on every 4th enabled cycle gives PERIOD=4.
- Cycles with CE=0 are invisible to the block:
  - cnt, state, PERIOD, LOCK and OVF all hold.
  - TICK is ignored.
- Lock tracking:
  - An internal match counter mcnt (4 bits) is kept alongside a flag "have previous".
  - On each measurement: if "have previous" is set and the new value equals the old PERIOD, mcnt<=min(mcnt+1, 15). Otherwise mcnt<=1.
  - LOCK<=(new mcnt >= LOCK_COUNT).
  - With LOCK_COUNT=1, LOCK asserts on the first measurement.
  - A mismatching measurement drops LOCK at the same edge that updates PERIOD.
- CLR=1: state<=IDLE, cnt<=0, mcnt<=0, PERIOD<=0, VALID<=0, LOCK<=0, OVF<=0. CLR applies regardless of CE.
- All arithmetic is unsigned. cnt never wraps; it saturates by taking the overflow path.

## Timing

- Reset values (NRST=0, asynchronous): state IDLE, cnt 0, mcnt 0, PERIOD 0, VALID 0, LOCK 0, OVF 0.
- Latency:
  - PERIOD, VALID, LOCK and OVF all change on the same rising edge that samples the qualifying TICK.
  - They are visible in the following cycle.
  - All outputs are registered, with no combinational path from inputs.
- VALID:
  - High for exactly one CLK cycle per measurement, even if CE drops in the next cycle.
  - VALID is never held high across consecutive cycles, except when ticks occur on consecutive enabled cycles (PERIOD=1).
- No handshake: the consumer must capture PERIOD during VALID or read the held value later.
- Reset mid-measurement: all state is lost. The next tick after NRST deasserts is treated as a first tick.
- Simultaneous CLR and TICK: CLR wins, and the tick is discarded.

## Test plan

- CE=1 constant, TICK every 4th cycle, WIDTH=8, LOCK_COUNT=2 -> first VALID with PERIOD=4 after the second tick; LOCK=1 from the second VALID onwards; OVF=0.
- CE toggling 1/0, TICK asserted on every 3rd enabled cycle -> PERIOD=3 regardless of the disabled cycles; nothing changes during CE=0.
- Locked at PERIOD=4, then one tick arrives at 5 -> VALID with PERIOD=5 and LOCK=0 at the same edge; two more ticks at period 5 -> LOCK=1 again.
- WIDTH=4: ticks 15 cycles apart -> PERIOD=15 with no OVF; then no tick for 15 enabled cycles -> OVF=1, LOCK=0, PERIOD still 15; next two ticks 6 apart -> PERIOD=6, OVF=0.
- Ticks on consecutive enabled cycles -> PERIOD=1 with VALID high continuously; CLR asserted together with a TICK -> all outputs 0, state IDLE, and that tick is not counted.
- Assert NRST low mid-count, asynchronously between clock edges -> outputs are 0 immediately; after release, the first tick produces no VALID.

Source files
------------

// File: rtl/tick_period_meter_if.sv
// Bus bundle for tick_period_meter: enable/clear/tick in, measurement out.
interface tick_period_meter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             CE;
  logic             CLR;
  logic             TICK;
  logic [WIDTH-1:0] PERIOD;
  logic             VALID;
  logic             LOCK;
  logic             OVF;

  // Producer of the tick stream / consumer of the measurement.
  modport master (
    output CE, CLR, TICK,
    input  PERIOD, VALID, LOCK, OVF
  );

  // The meter itself.
  modport slave (
    input  CE, CLR, TICK,
    output PERIOD, VALID, LOCK, OVF
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the spacing of CE-qualified TICK strobes, publishes each period
// with a one-cycle VALID, tracks lock on repeated identical periods and
// flags a sticky overflow when no tick arrives within the counter range.
module tick_period_meter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic                  CLK,
  input  logic                  NRST,
  tick_period_meter_if.slave    bus
);

  localparam int unsigned MCNT_W = 4;
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  cnt;
  logic [MCNT_W-1:0] mcnt;
  logic [MCNT_W-1:0] mcnt_next_c;

  // Match count for the measurement being taken this cycle; a zero mcnt
  // doubles as "no previous measurement to compare against".
  always_comb begin
    mcnt_next_c = MCNT_W'(1);
    if ((mcnt != '0) && (cnt == bus.PERIOD)) begin
      mcnt_next_c = (mcnt == MCNT_MAX) ? MCNT_MAX : mcnt + MCNT_W'(1);
    end
  end

  // Measurement FSM with registered outputs; CE=0 cycles only retire VALID.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      cnt        <= '0;
      mcnt       <= '0;
      bus.PERIOD <= '0;
      bus.VALID  <= 1'b0;
      bus.LOCK   <= 1'b0;
      bus.OVF    <= 1'b0;
    end else begin
      bus.VALID <= 1'b0;
      if (bus.CLR) begin
        state      <= IDLE;
        cnt        <= '0;
        mcnt       <= '0;
        bus.PERIOD <= '0;
        bus.LOCK   <= 1'b0;
        bus.OVF    <= 1'b0;
      end else if (bus.CE) begin
        case (state)
          IDLE: begin
            if (bus.TICK) begin
              cnt   <= WIDTH'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (bus.TICK) begin
              bus.PERIOD <= cnt;
              bus.VALID  <= 1'b1;
              bus.OVF    <= 1'b0;
              bus.LOCK   <= (32'(mcnt_next_c) >= 32'(LOCK_COUNT));
              mcnt       <= mcnt_next_c;
              cnt        <= WIDTH'(1);
            end else if (cnt == CNT_MAX) begin
              // Saturated without a tick: drop lock and resynchronise.
              bus.OVF  <= 1'b1;
              bus.LOCK <= 1'b0;
              mcnt     <= '0;
              cnt      <= '0;
              state    <= IDLE;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: one 8-bit instance (LOCK_COUNT=2)
// and one 4-bit instance (LOCK_COUNT=1) for the overflow boundary.
module tb_tick_period_meter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tick_period_meter_if #(.WIDTH(8)) ia ();
  tick_period_meter_if #(.WIDTH(4)) ib ();

  tick_period_meter #(.WIDTH(8), .LOCK_COUNT(2)) dut_a (
    .CLK  (clk),
    .NRST (rst_n),
    .bus  (ia.slave)
  );

  tick_period_meter #(.WIDTH(4), .LOCK_COUNT(1)) dut_b (
    .CLK  (clk),
    .NRST (rst_n),
    .bus  (ib.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic exp_a(input string tag, input int p, input int v, input int l, input int o);
    check({tag, ".period"}, 32'(ia.PERIOD), 32'(p));
    check({tag, ".valid"},  32'(ia.VALID),  32'(v));
    check({tag, ".lock"},   32'(ia.LOCK),   32'(l));
    check({tag, ".ovf"},    32'(ia.OVF),    32'(o));
  endtask

  task automatic exp_b(input string tag, input int p, input int v, input int l, input int o);
    check({tag, ".period"}, 32'(ib.PERIOD), 32'(p));
    check({tag, ".valid"},  32'(ib.VALID),  32'(v));
    check({tag, ".lock"},   32'(ib.LOCK),   32'(l));
    check({tag, ".ovf"},    32'(ib.OVF),    32'(o));
  endtask

  // Inputs applied at a falling edge, consumed at the next rising edge,
  // outputs observed at the following falling edge.
  task automatic cyc_a(input logic ce, input logic tick, input logic clr);
    ia.CE = ce; ia.TICK = tick; ia.CLR = clr;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic ce, input logic tick, input logic clr);
    ib.CE = ce; ib.TICK = tick; ib.CLR = clr;
    @(negedge clk);
  endtask

  // p-1 enabled idle cycles then an enabled tick.
  task automatic gap_a(input int p);
    for (int i = 1; i < p; i++) cyc_a(1'b1, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b1, 1'b0);
  endtask

  // Same, but each enabled cycle is followed by a disabled one with TICK=1.
  task automatic gap_a_toggle(input int p, input string tag, input int l);
    for (int i = 1; i <= p; i++) begin
      cyc_a(1'b1, (i == p), 1'b0);
      if (i == p) exp_a({tag, ".tick"}, p, 1, l, 0);
      cyc_a(1'b0, 1'b1, 1'b0);
      if (i == p) exp_a({tag, ".hold"}, p, 0, l, 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ia.CE = 1'b0; ia.TICK = 1'b0; ia.CLR = 1'b0;
    ib.CE = 1'b0; ib.TICK = 1'b0; ib.CLR = 1'b0;
    repeat (2) @(negedge clk);
    exp_a("rst_a", 0, 0, 0, 0);
    exp_b("rst_b", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Constant CE, tick every 4th cycle.
    cyc_a(1'b1, 1'b1, 1'b0);
    exp_a("first_tick", 0, 0, 0, 0);
    gap_a(4);
    exp_a("p4_first", 4, 1, 0, 0);
    cyc_a(1'b1, 1'b0, 1'b0);
    exp_a("p4_pulse_end", 4, 0, 0, 0);
    gap_a(3);
    exp_a("p4_lock", 4, 1, 1, 0);
    gap_a(4);
    exp_a("p4_lock2", 4, 1, 1, 0);

    // One period of 5 breaks lock, a second one restores it.
    gap_a(5);
    exp_a("p5_break", 5, 1, 0, 0);
    gap_a(5);
    exp_a("p5_relock", 5, 1, 1, 0);
    gap_a(5);
    exp_a("p5_stay", 5, 1, 1, 0);

    // CE toggling, disabled cycles carry TICK=1 which must be ignored.
    gap_a_toggle(3, "ce_p3a", 0);
    gap_a_toggle(3, "ce_p3b", 1);

    // Back-to-back enabled ticks.
    cyc_a(1'b1, 1'b1, 1'b0);
    exp_a("p1_a", 1, 1, 0, 0);
    cyc_a(1'b1, 1'b1, 1'b0);
    exp_a("p1_b", 1, 1, 1, 0);

    // CLR together with TICK: everything clears and the tick is dropped.
    cyc_a(1'b1, 1'b1, 1'b1);
    exp_a("clr_tick", 0, 0, 0, 0);
    cyc_a(1'b1, 1'b1, 1'b0);
    exp_a("after_clr_first", 0, 0, 0, 0);
    gap_a(2);
    exp_a("after_clr_p2", 2, 1, 0, 0);
    cyc_a(1'b0, 1'b0, 1'b0);

    // 4-bit instance: period at the counter maximum, then overflow.
    cyc_b(1'b1, 1'b1, 1'b0);
    exp_b("b_first", 0, 0, 0, 0);
    for (int i = 1; i < 15; i++) cyc_b(1'b1, 1'b0, 1'b0);
    cyc_b(1'b1, 1'b1, 1'b0);
    exp_b("b_p15", 15, 1, 1, 0);
    for (int i = 1; i < 15; i++) cyc_b(1'b1, 1'b0, 1'b0);
    exp_b("b_edge", 15, 0, 1, 0);
    cyc_b(1'b1, 1'b0, 1'b0);
    exp_b("b_ovf", 15, 0, 0, 1);
    cyc_b(1'b1, 1'b1, 1'b0);
    exp_b("b_resync", 15, 0, 0, 1);
    for (int i = 1; i < 6; i++) cyc_b(1'b1, 1'b0, 1'b0);
    cyc_b(1'b1, 1'b1, 1'b0);
    exp_b("b_p6", 6, 1, 1, 0);
    cyc_b(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count on the 8-bit instance.
    cyc_a(1'b1, 1'b0, 1'b0);
    ia.CE = 1'b0;
    #2 rst_n = 1'b0;
    #1 exp_a("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc_a(1'b1, 1'b1, 1'b0);
    exp_a("post_rst_first", 0, 0, 0, 0);
    gap_a(2);
    exp_a("post_rst_p2", 2, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
